ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Parametrised successor to the fixed three-key keyboard decoder. Receives PS/2 keyboard frames and decodes make, break and E0-extended scan codes against a parameter table of NUM_KEYS entries. Produces per-key held levels, one-cycle press and release pulses, and raw-byte and error diagnostics. Sits between the keyboard pins and the game control block; it replaces the hard-wired space/up/down outputs.

Parameters:
NUM_KEYS, 3, number of decoded key channels (1..16)
KEY_CODES, {9'h029,9'h175,9'h172}, NUM_KEYS x 9-bit entries {ext,code}; entry i occupies bits [9i+8:9i]; default is ch2=space, ch1=up(E0 75), ch0=down(E0 72)
FILTER_LEN, 4, number of consecutive equal samples required before filtered kb_clk changes
TIMEOUT_CYCLES, 100000, clk cycles without a filtered falling edge mid-frame before the frame is aborted (1 ms at 100 MHz)

Ports:
clk  in  1  system clock
clr  in  1  synchronous active-high reset
kb_clk  in  1  PS/2 clock pin, asynchronous
kb_data  in  1  PS/2 data pin, asynchronous
key_held  out  NUM_KEYS  level; 1 while key i is down
key_press  out  NUM_KEYS  1-cycle pulse on the first make of key i
key_release  out  NUM_KEYS  1-cycle pulse on the break of a held key i
frame_valid  out  1  1-cycle pulse for every good byte, including prefixes
frame_code  out  8  last good byte; holds its value between frames
frame_err  out  1  1-cycle pulse on a parity, stop-bit or timeout error

Behaviour:
- Reset: clr is sampled on the rising edge of clk. All outputs, the shift register, the prefix flags and the timeout counter go to 0; the FSM goes to IDLE. Reset mid-frame discards the partial frame; held keys are cleared without release pulses.
- Input conditioning: kb_clk and kb_data each pass through a 2-flop synchroniser. Filtered kb_clk changes only after FILTER_LEN consecutive equal synchronised samples. A falling edge of filtered kb_clk is a 1-cycle strobe (fe); kb_data is sampled on fe.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with data=0, go to DATA with bit count 0. On fe with data=1, stay in IDLE; this is a silent discard with no error.
  - DATA: on each fe, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fe, latch the bit and go to STOP.
  - STOP: on fe, check for odd parity over the 8 data bits plus the parity bit, and check stop bit = 1.
    - Pass: pulse frame_valid and load frame_code.
    - Fail: pulse frame_err, clear the prefix flags, produce no key activity.
    - In both cases go to IDLE.
- Timeout: the counter resets on every fe and counts in DATA, PARITY and STOP. On reaching TIMEOUT_CYCLES: pulse frame_err, clear the prefix flags, go to IDLE.
- Latency: frame_valid, frame_code, key_press, key_release and key_held all update on the clk edge following the fe cycle of the stop bit.
- Byte interpretation (good bytes only):
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte b forms {ext,b}, then clears ext and brk in the same cycle. For every entry i with KEY_CODES[i] == {ext,b}:
    - brk=0 and key_held[i]=0: set key_held[i], pulse key_press[i].
    - brk=0 and key_held[i]=1: typematic repeat; no change and no pulse.
    - brk=1 and key_held[i]=1: clear key_held[i], pulse key_release[i].
    - brk=1 and key_held[i]=0: no effect.
  - Bytes matching no entry only clear ext and brk.
- Duplicate table entries: all matching channels update in the same cycle. Several channels may pulse at once.
- Prefix order: E0 then F0 is the extended break, per the protocol. F0 then E0 is also accepted; both flags persist until a non-prefix byte arrives.

Test Plan:
- Make 29, break F0 29 on defaults: key_press[2] pulses once; key_held[2] rises in the same cycle; key_release[2] pulses after F0 29; frame_valid pulses 3 times; frame_code ends at 29.
- Extended make: E0 75 → key_held[1]=1, key_press[1] pulses. Plain 75 (keypad 8) → no change on any channel. E0 F0 75 → key_release[1] pulses.
- Typematic: 29 sent 5 times → exactly 1 key_press[2] pulse; key_held[2] stays 1; then F0 29 → 1 release pulse.
- Bad parity on byte 29 → frame_err pulses; no frame_valid and no key change. A following good F0 29 with the key not held → no release pulse.
- Timeout: start bit plus 3 data bits, then clock stops → frame_err exactly TIMEOUT_CYCLES after the last fe; the FSM returns to IDLE; the next full frame 29 decodes correctly.
- Glitch and reset: a kb_clk pulse shorter than FILTER_LEN cycles → ignored. clr asserted mid-frame with key 2 held → all outputs 0 the next cycle and no release pulse.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the pins, frames bytes, and decodes make/break/E0
// scan codes against a parameter table into per-key held levels and press/release pulses.
module ps2_key_decoder #(
  parameter int                    NUM_KEYS       = 3,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h029, 9'h175, 9'h172},
  parameter int                    FILTER_LEN     = 4,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                kb_clk,
  input  logic                kb_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                frame_valid,
  output logic [7:0]          frame_code,
  output logic                frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_clk_sync;
  logic [1:0]          r_data_sync;
  logic                r_kb_clk_f;
  logic [FCW-1:0]      r_filt_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_parity;
  logic [TCW-1:0]      r_to_cnt;
  logic                r_ext;
  logic                r_brk;
  logic [NUM_KEYS-1:0] r_held;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic                r_valid;
  logic [7:0]          r_code;
  logic                r_err;

  logic                w_clk_s;
  logic                w_data;
  logic                w_flip;
  logic                w_fe;
  logic                w_to_hit;
  logic                w_start;
  logic                w_shift_en;
  logic                w_par_ld;
  logic                w_stop;
  logic                w_timeout;
  logic                w_frame_ok;
  logic                w_frame_bad;
  logic                w_key_byte;
  logic [NUM_KEYS-1:0] w_match;
  logic [NUM_KEYS-1:0] w_press_nxt;
  logic [NUM_KEYS-1:0] w_release_nxt;

  assign w_clk_s = r_clk_sync[1];
  assign w_data  = r_data_sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], kb_clk};
      r_data_sync <= {r_data_sync[0], kb_data};
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  assign w_flip = (w_clk_s != r_kb_clk_f) && (r_filt_cnt == FCW'(FILTER_LEN - 1));
  assign w_fe   = w_flip && r_kb_clk_f;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_kb_clk_f <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_kb_clk_f) begin
      r_filt_cnt <= '0;
    end else if (w_flip) begin
      r_kb_clk_f <= w_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_to_hit = (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_par_ld    = 1'b0;
    w_stop      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fe && !w_data) begin
          w_start     = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fe) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_fe) begin
          w_par_ld    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fe) begin
          w_stop      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && !w_fe && w_to_hit) begin
      w_timeout   = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_start)    r_bit_cnt <= '0;
      if (w_shift_en) begin
        r_shift   <= {w_data, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_par_ld)   r_parity <= w_data;
      if (w_fe || w_timeout || (r_state == S_IDLE)) r_to_cnt <= '0;
      else                                          r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Odd parity: the eight data bits plus the parity bit must XOR to 1.
  assign w_frame_ok  = w_stop && (^{r_shift, r_parity}) && w_data;
  assign w_frame_bad = (w_stop && !((^{r_shift, r_parity}) && w_data)) || w_timeout;
  assign w_key_byte  = w_frame_ok && (r_shift != 8'hE0) && (r_shift != 8'hF0);

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_match[i] = (KEY_CODES[9*i +: 9] == {r_ext, r_shift});
    end
  end

  assign w_press_nxt   = (w_key_byte && !r_brk) ? (w_match & ~r_held) : '0;
  assign w_release_nxt = (w_key_byte &&  r_brk) ? (w_match &  r_held) : '0;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_held    <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_held    <= (r_held | w_press_nxt) & ~w_release_nxt;
      r_valid   <= w_frame_ok;
      r_err     <= w_frame_bad;
      if (w_frame_ok) r_code <= r_shift;
      if (w_frame_bad || w_key_byte) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_frame_ok && (r_shift == 8'hE0)) begin
        r_ext <= 1'b1;
      end else if (w_frame_ok && (r_shift == 8'hF0)) begin
        r_brk <= 1'b1;
      end
    end
  end

  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign frame_valid = r_valid;
  assign frame_code  = r_code;
  assign frame_err   = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a byte-level behavioural model checked against the DUT every
// cycle, plus directed literal expectations on pulse counts, held levels and timing.
module tb_ps2_key_decoder;

  localparam int NK   = 3;
  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;
  localparam logic [8:0] KEY_TABLE [NK] = '{9'h172, 9'h175, 9'h029};

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          kb_clk = 1'b1;
  logic          kb_data = 1'b1;
  logic [NK-1:0] key_held, key_press, key_release;
  logic          frame_valid, frame_err;
  logic [7:0]    frame_code;

  ps2_key_decoder #(
    .NUM_KEYS(NK), .KEY_CODES({9'h029, 9'h175, 9'h172}),
    .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .clr(clr), .kb_clk(kb_clk), .kb_data(kb_data),
    .key_held(key_held), .key_press(key_press), .key_release(key_release),
    .frame_valid(frame_valid), .frame_code(frame_code), .frame_err(frame_err)
  );

  initial forever #5 clk = ~clk;

  // Model state, written only by the model process.
  logic [NK-1:0] m_held = '0, m_press = '0, m_release = '0;
  logic          m_valid = 1'b0, m_err = 1'b0;
  logic [7:0]    m_code = '0;
  bit            m_ext = 1'b0, m_brk = 1'b0;
  int            m_seq = 0;

  // Byte events handed from the stimulus to the model, written only by the main process.
  int         ev_seq = 0;
  bit         ev_is_err = 1'b0;
  logic [7:0] ev_byte = '0;

  int n_tests = 0, n_fail = 0;
  bit cmp_en = 1'b0;
  int obs_press [NK], obs_release [NK], base_press [NK], base_release [NK];
  int obs_valid = 0, obs_err = 0, base_valid = 0, base_err = 0;

  task automatic model_apply(input bit is_err, input logic [7:0] b);
    if (is_err) begin
      m_err = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_valid = 1'b1;
      m_code  = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        for (int i = 0; i < NK; i++) begin
          if (KEY_TABLE[i] == {m_ext, b}) begin
            if (!m_brk && !m_held[i]) begin
              m_held[i]  = 1'b1;
              m_press[i] = 1'b1;
            end else if (m_brk && m_held[i]) begin
              m_held[i]    = 1'b0;
              m_release[i] = 1'b1;
            end
          end
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_press = '0; m_release = '0; m_valid = 1'b0; m_err = 1'b0;
      if (clr) begin
        m_held = '0; m_code = '0; m_ext = 1'b0; m_brk = 1'b0;
        m_seq  = ev_seq;
      end else if (m_seq != ev_seq) begin
        m_seq = ev_seq;
        model_apply(ev_is_err, ev_byte);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock step: sample on the falling edge, compare to the model, count DUT pulses.
  task automatic tick();
    @(negedge clk);
    if (cmp_en) begin
      n_tests++;
      if (key_held !== m_held || key_press !== m_press || key_release !== m_release ||
          frame_valid !== m_valid || frame_code !== m_code || frame_err !== m_err) begin
        n_fail++;
        $display("FAIL cycle_compare @%0t dut/model: held=%b/%b press=%b/%b rel=%b/%b valid=%b/%b code=%h/%h err=%b/%b",
                 $time, key_held, m_held, key_press, m_press, key_release, m_release,
                 frame_valid, m_valid, frame_code, m_code, frame_err, m_err);
      end
      for (int i = 0; i < NK; i++) begin
        if (key_press[i] === 1'b1)   obs_press[i]++;
        if (key_release[i] === 1'b1) obs_release[i]++;
      end
      if (frame_valid === 1'b1) obs_valid++;
      if (frame_err === 1'b1)   obs_err++;
    end
  endtask

  task automatic post(input bit is_err, input logic [7:0] b);
    ev_is_err = is_err;
    ev_byte   = b;
    ev_seq++;
  endtask

  task automatic snap();
    for (int i = 0; i < NK; i++) begin
      base_press[i]   = obs_press[i];
      base_release[i] = obs_release[i];
    end
    base_valid = obs_valid;
    base_err   = obs_err;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Sends the first n bits of a frame; the byte outcome is posted FL+1 cycles into
  // the stop-bit low phase, which lands the model on the DUT's update edge.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit is_err, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      kb_data = bits[i];
      repeat (HALF) tick();
      kb_clk = 1'b0;
      for (int c = 1; c <= HALF; c++) begin
        tick();
        if (i == 10 && c == FL + 1) post(is_err, b);
      end
      kb_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    send_bits(frame_bits(b, bad_par, bad_stop), 11, bad_par | bad_stop, b);
    kb_data = 1'b1;
    repeat (2 * HALF) tick();
  endtask

  int first_err_c;

  initial begin
    for (int i = 0; i < NK; i++) begin
      obs_press[i] = 0; obs_release[i] = 0; base_press[i] = 0; base_release[i] = 0;
    end
    clr = 1'b1;
    repeat (3) tick();
    cmp_en = 1'b1;
    tick();
    check("reset_held", key_held, 3'b000);
    check("reset_code", frame_code, 8'h00);
    check("reset_valid", frame_valid, 1'b0);
    clr = 1'b0;
    repeat (10) tick();

    // Plain make and break of space.
    snap();
    send_frame(8'h29);
    check("t1_held_after_make", key_held, 3'b100);
    check("t1_press2", obs_press[2] - base_press[2], 1);
    send_frame(8'hF0);
    send_frame(8'h29);
    check("t1_release2", obs_release[2] - base_release[2], 1);
    check("t1_valid_count", obs_valid - base_valid, 3);
    check("t1_code", frame_code, 8'h29);
    check("t1_held_after_break", key_held, 3'b000);

    // Extended keys in both prefix orders; unprefixed 75 must not match.
    snap();
    send_frame(8'hE0); send_frame(8'h75);
    check("t2_held_up", key_held, 3'b010);
    check("t2_press1", obs_press[1] - base_press[1], 1);
    send_frame(8'h75);
    check("t2_plain75_held", key_held, 3'b010);
    check("t2_plain75_presses",
          (obs_press[0] - base_press[0]) + (obs_press[1] - base_press[1]) + (obs_press[2] - base_press[2]), 1);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    check("t2_release1_e0f0", obs_release[1] - base_release[1], 1);
    check("t2_held_clear", key_held, 3'b000);
    send_frame(8'hE0); send_frame(8'h75);
    send_frame(8'hF0); send_frame(8'hE0); send_frame(8'h75);
    check("t2_release1_f0e0", obs_release[1] - base_release[1], 2);
    check("t2_press1_total", obs_press[1] - base_press[1], 2);

    // Typematic repeat.
    snap();
    repeat (5) send_frame(8'h29);
    check("t3_single_press", obs_press[2] - base_press[2], 1);
    check("t3_held", key_held, 3'b100);
    send_frame(8'hF0); send_frame(8'h29);
    check("t3_single_release", obs_release[2] - base_release[2], 1);

    // Frame errors: no key effect, and an error drops a pending F0.
    snap();
    send_frame(8'h29, 1'b1, 1'b0);
    check("t4_parity_err", obs_err - base_err, 1);
    check("t4_parity_no_valid", obs_valid - base_valid, 0);
    check("t4_parity_held", key_held, 3'b000);
    send_frame(8'hF0); send_frame(8'h29);
    check("t4_no_release", obs_release[2] - base_release[2], 0);
    send_frame(8'hF0);
    send_frame(8'h29, 1'b0, 1'b1);
    check("t4_stop_err", obs_err - base_err, 2);
    send_frame(8'h29);
    check("t4_prefix_dropped_make", key_held, 3'b100);
    check("t4_press_count", obs_press[2] - base_press[2], 1);
    send_frame(8'hF0); send_frame(8'h29);

    // Timeout: start + 3 data bits, then silence. The error is due TO cycles after the
    // edge at which a byte from that fe would appear: negedge FL+2+TO = 206 after the drop.
    snap();
    first_err_c = 0;
    send_bits(frame_bits(8'h29, 1'b0, 1'b0), 4, 1'b0, 8'h00);
    kb_data = 1'b1;
    for (int c = HALF + 1; c <= FL + TO + HALF; c++) begin
      tick();
      if (c == FL + 1 + TO) post(1'b1, 8'h00);
      if (frame_err === 1'b1 && first_err_c == 0) first_err_c = c;
    end
    check("t5_timeout_cycle", first_err_c, 206);
    check("t5_timeout_err", obs_err - base_err, 1);
    check("t5_timeout_no_valid", obs_valid - base_valid, 0);
    send_frame(8'h29);
    check("t5_recover_held", key_held, 3'b100);
    check("t5_recover_code", frame_code, 8'h29);
    send_frame(8'hF0); send_frame(8'h29);

    // Glitch shorter than the filter, with data low so a real edge would start a frame.
    snap();
    kb_data = 1'b0;
    kb_clk  = 1'b0;
    repeat (FL - 1) tick();
    kb_clk = 1'b1;
    repeat (TO + 50) tick();
    kb_data = 1'b1;
    repeat (HALF) tick();
    check("t6_glitch_no_err", obs_err - base_err, 0);
    check("t6_glitch_no_valid", obs_valid - base_valid, 0);
    send_frame(8'h29);
    check("t6_after_glitch_held", key_held, 3'b100);
    check("t6_after_glitch_valid", obs_valid - base_valid, 1);

    // Reset mid-frame with space held.
    snap();
    send_bits(frame_bits(8'hF0, 1'b0, 1'b0), 4, 1'b0, 8'h00);
    kb_data = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t7_clr_held", key_held, 3'b000);
    check("t7_clr_code", frame_code, 8'h00);
    check("t7_clr_release", key_release, 3'b000);
    repeat (TO + 50) tick();
    check("t7_no_release", obs_release[2] - base_release[2], 0);
    check("t7_no_err", obs_err - base_err, 0);
    send_frame(8'h29);
    check("t7_fresh_press", obs_press[2] - base_press[2], 1);
    check("t7_fresh_held", key_held, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
